// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
// Occupancy-counter width is derived here so the flow does not depend on $clog2.
package dff_pipe_pkg;

  function automatic int clog2_ceil(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Counter must represent 0..DEPTH inclusive, and is never narrower than 1 bit.
  function automatic int cnt_width(input int depth);
    return (clog2_ceil(depth + 1) < 1) ? 1 : clog2_ceil(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Valid/ready handshake bundle for both ends of dff_pipe.
// The master modport is the producer/consumer side; the slave modport is the pipeline.
interface dff_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_vld;
  logic [WIDTH-1:0] in_dat;
  logic             in_rdy;
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             out_rdy;

  modport master (
    output in_vld, in_dat, out_rdy,
    input  in_rdy, out_vld, out_dat
  );

  modport slave (
    input  in_vld, in_dat, out_rdy,
    output in_rdy, out_vld, out_dat
  );
endinterface

// File: rtl/dff_pipe_stage.sv
// One valid/data register pair: clear beats load beats drain, and unloaded data holds.
// Latency: one cycle; backpressure is decided by the caller through load_i/drain_i.
module dff_pipe_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clr_i) begin
      vld_d = 1'b0;
      dat_d = RESET_VAL;
    end else if (load_i) begin
      vld_d = 1'b1;
      dat_d = d_i;
    end else if (drain_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with bubble collapse, global hold and flush.
// Latency DEPTH cycles unstalled, 1 word/cycle; ready is combinational from the move chain.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = cnt_width(DEPTH)
) (
  input  logic             core_clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             flush_i,
  dff_pipe_if.slave        bus,
  output logic [CNT_W-1:0] count_o
);
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] count_q, count_d;

  // A stage advances when downstream is empty or itself advancing, so bubbles collapse.
  assign move[DEPTH-1] = vld[DEPTH-1] & bus.out_rdy & enable_i;
  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_move
    assign move[i] = vld[i] & (~vld[i+1] | move[i+1]) & enable_i;
  end

  assign bus.in_rdy = ~rst_i & enable_i & ~flush_i & (~vld[0] | move[0]);
  assign accept     = bus.in_vld & bus.in_rdy;
  assign pop        = vld[DEPTH-1] & bus.out_rdy & enable_i & ~flush_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign load[i]    = accept;
      assign stage_d[i] = bus.in_dat;
    end else begin : g_body
      assign load[i]    = move[i-1];
      assign stage_d[i] = dat[i-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_i   (core_clk_i),
      .rst_i   (rst_i),
      .clr_i   (flush_i),
      .load_i  (load[i]),
      .drain_i (move[i]),
      .d_i     (stage_d[i]),
      .vld_o   (vld[i]),
      .dat_o   (dat[i])
    );
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge core_clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bus.out_vld = vld[DEPTH-1];
  assign bus.out_dat = dat[DEPTH-1];
  assign count_o     = count_q;
endmodule
